lsu_issue_queue: RTL and testbench
==================================

// Module: lsu_issue_queue
// PURPOSE
//  Memory-op reservation station between dispatch and the load/store unit. Holds loads/stores
//  with their LQ/SQ slot, ROB index and source tags; tracks operand readiness via writeback
//  wakeup. Issues the oldest ready op per cycle to register-read/EX, which drives the LSU
//  ld/st issue (EX_ld_idx/EX_st_idx).
// PARAMETERS
//  DEPTH      4   queue entries (power of 2, >=2)
//  TAG_W      7   physical register tag width
//  ROB_W      3   ROB index width; flush_mask is 2**ROB_W bits
//  LSQ_W      2   LQ/SQ index width
//  NUM_WB     2   writeback wakeup broadcast ports
// PORTS
//  clk           in   1            clock
//  rst           in   1            async reset, active-low
//  dc_valid      in   1            dispatch offers an op (FU select already load(6) or store(7))
//  dc_is_st      in   1            1=store, 0=load
//  dc_rob_idx    in   ROB_W        ROB slot
//  dc_lsq_idx    in   LSQ_W        LQ_tail (load) or SQ_tail (store) at dispatch
//  dc_rs1_tag    in   TAG_W        base-address source tag
//  dc_rs2_tag    in   TAG_W        store-data source tag (ignored for loads)
//  dc_rs1_rdy    in   1            rs1 ready at dispatch
//  dc_rs2_rdy    in   1            rs2 ready at dispatch
//  dc_imm        in   32           sign-extended offset
//  dc_funct3     in   3            access size/sign
//  dc_ready      out  1            free entry exists
//  wb_valid      in   NUM_WB       wakeup broadcast valid
//  wb_tag        in   NUM_WB*TAG_W wakeup tags
//  is_valid      out  1            issue offer
//  is_ready      in   1            RR/EX accepts (for loads also reflects ld_i_ready)
//  is_st         out  1            issued op is store
//  is_rob_idx    out  ROB_W        ROB slot
//  is_lsq_idx    out  LSQ_W        LQ/SQ index -> EX_ld_idx / EX_st_idx
//  is_rs1_tag    out  TAG_W        to register read
//  is_rs2_tag    out  TAG_W        to register read
//  is_imm        out  32           offset
//  is_funct3     out  3            access size/sign
//  mispredict    in   1            flush request
//  flush_mask    in   2**ROB_W     ROB slots to squash
// BEHAVIOUR
//  - Reset (rst=0, async): all entries invalid, age matrix cleared; dc_ready=1, is_valid=0,
//    all is_* data outputs 0.
//  - Entry: valid, is_st, rob_idx, lsq_idx, tags, rdy1, rdy2, imm, funct3.
//    Load treats rdy2 as 1 on allocation.
//  - Allocate on dc_valid && dc_ready into the lowest-index free entry.
//    dc_ready = !(all valid), from registered state only. An issue in the same cycle does not
//    free a slot for that cycle's dispatch.
//  - Wakeup: each cycle, any valid entry whose tag matches a valid wb_tag sets the rdy bit.
//    A dispatching op whose tag matches a same-cycle wb_tag is allocated ready.
//  - Select: combinational over registered state. Candidate = valid && rdy1 && rdy2.
//    Pick the oldest candidate via age matrix (older[i][j]=1 when i allocated before j;
//    set on allocation against all current valid entries).
//    Wake-to-issue = 1 cycle minimum; dispatch-to-issue = 1 cycle minimum.
//  - is_valid = any candidate; is_* reflect the selected entry while is_valid, else 0.
//    On is_valid && is_ready the entry is invalidated at the clock edge.
//    If is_ready=0, the selection may change next cycle (older op woken); no hold contract.
//  - Mispredict: entries with flush_mask[rob_idx]=1 are invalidated at the edge.
//    Same-cycle dispatch is dropped. Same-cycle issue handshake still completes;
//    downstream squashes by flush_mask.
//  - Simultaneous issue and flush of the same entry: entry invalid next cycle, single removal.
//  - Loads and stores issue out of order relative to each other. Memory ordering is resolved
//    in the LSU via LQ SQ_t snapshot; no ordering is enforced here.
// STRUCTURE
//  - Shared package ooo_pkg: lsu_iq_entry_t typedef, FU_LD=3'd6, FU_ST=3'd7, funct3 LB..SW macros.
//  - Sub-module age_matrix_select (DEPTH, req vector, alloc one-hot, clear vector -> grant
//    one-hot + valid); reusable by ALU/branch queues.
// TESTING
//  1. Reset mid-operation with 3 valid entries -> next cycle dc_ready=1, is_valid=0,
//     all is_* outputs 0.
//  2. Dispatch ld rob=2 lsq=1 rs1 ready, is_ready=1 -> cycle+1 is_valid=1, is_lsq_idx=1,
//     is_rob_idx=2; entry freed.
//  3. Fill 4 entries with rs1_tag=9 not ready -> dc_ready=0, is_valid=0.
//     wb_tag=9 -> next cycle the oldest (first dispatched) issues first; then one per cycle
//     in age order.
//  4. Store rs1 ready, rs2_tag=12 pending -> no issue until wb_tag=12; issue exactly 1 cycle
//     after wakeup.
//  5. Entries rob 1,3,5; mispredict with flush_mask=8'b0010_1000 -> only rob 1 remains;
//     same-cycle dispatch rob=6 dropped.
//  6. is_ready=0 for 5 cycles with 1 ready entry -> is_valid held 1, entry retained,
//     issues once when is_ready=1.

Source files
------------

// File: rtl/ooo_pkg.sv
// rtl/ooo_pkg.sv - shared out-of-order core types, FU codes and access-size encodings
package ooo_pkg;

  localparam logic [2:0] FU_LD = 3'd6;
  localparam logic [2:0] FU_ST = 3'd7;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int IQ_TAG_W = 7;
  localparam int IQ_ROB_W = 3;
  localparam int IQ_LSQ_W = 2;

  // Reference entry layout at the default core widths
  typedef struct packed {
    logic                is_st;
    logic [IQ_ROB_W-1:0] rob_idx;
    logic [IQ_LSQ_W-1:0] lsq_idx;
    logic [IQ_TAG_W-1:0] rs1_tag;
    logic [IQ_TAG_W-1:0] rs2_tag;
    logic                rdy1;
    logic                rdy2;
    logic [31:0]         imm;
    logic [2:0]          funct3;
  } lsu_iq_entry_t;

endpackage

// File: rtl/age_matrix_select.sv
// rtl/age_matrix_select.sv - oldest-first grant over a request vector using an age matrix
module age_matrix_select #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] req,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] clear,
  output logic [DEPTH-1:0] grant,
  output logic             grant_valid
);

  // older[i][j] = 1 when slot i was allocated before slot j
  logic [DEPTH-1:0] older [DEPTH];

  // A new slot is younger than every other slot; relations with empty slots are
  // rewritten when those slots are next allocated, so no valid vector is needed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (alloc[j] && (i != j)) older[i][j] <= 1'b1;
          else if (alloc[i] || clear[i]) older[i][j] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = req[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (req[j] && older[j][i]) grant[i] = 1'b0;
      end
    end
  end

  assign grant_valid = |req;

endmodule

// File: rtl/lsu_issue_queue.sv
// rtl/lsu_issue_queue.sv - load/store reservation station issuing the oldest ready op per cycle
module lsu_issue_queue
  import ooo_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = IQ_TAG_W,
  parameter int ROB_W  = IQ_ROB_W,
  parameter int LSQ_W  = IQ_LSQ_W,
  parameter int NUM_WB = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dc_valid,
  input  logic                    dc_is_st,
  input  logic [ROB_W-1:0]        dc_rob_idx,
  input  logic [LSQ_W-1:0]        dc_lsq_idx,
  input  logic [TAG_W-1:0]        dc_rs1_tag,
  input  logic [TAG_W-1:0]        dc_rs2_tag,
  input  logic                    dc_rs1_rdy,
  input  logic                    dc_rs2_rdy,
  input  logic [31:0]             dc_imm,
  input  logic [2:0]              dc_funct3,
  output logic                    dc_ready,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*TAG_W-1:0] wb_tag,
  output logic                    is_valid,
  input  logic                    is_ready,
  output logic                    is_st,
  output logic [ROB_W-1:0]        is_rob_idx,
  output logic [LSQ_W-1:0]        is_lsq_idx,
  output logic [TAG_W-1:0]        is_rs1_tag,
  output logic [TAG_W-1:0]        is_rs2_tag,
  output logic [31:0]             is_imm,
  output logic [2:0]              is_funct3,
  input  logic                    mispredict,
  input  logic [(1<<ROB_W)-1:0]   flush_mask
);

  typedef struct packed {
    logic             is_st;
    logic [ROB_W-1:0] rob_idx;
    logic [LSQ_W-1:0] lsq_idx;
    logic [TAG_W-1:0] rs1_tag;
    logic [TAG_W-1:0] rs2_tag;
    logic             rdy1;
    logic             rdy2;
    logic [31:0]      imm;
    logic [2:0]       funct3;
  } entry_t;

  logic [DEPTH-1:0] valid_q;
  entry_t           ent_q [DEPTH];

  logic [DEPTH-1:0] alloc_oh;
  logic [DEPTH-1:0] alloc_vec;
  logic [DEPTH-1:0] req;
  logic [DEPTH-1:0] grant;
  logic [DEPTH-1:0] issue_clr;
  logic [DEPTH-1:0] flush_clr;
  logic             do_alloc;
  entry_t           new_ent;
  entry_t           sel;

  function automatic logic tag_hit(input logic [TAG_W-1:0] tag);
    tag_hit = 1'b0;
    for (int w = 0; w < NUM_WB; w++) begin
      if (wb_valid[w] && (wb_tag[w*TAG_W +: TAG_W] == tag)) tag_hit = 1'b1;
    end
  endfunction

  assign dc_ready = ~&valid_q;
  assign do_alloc = dc_valid & dc_ready & ~mispredict;

  always_comb begin
    alloc_oh = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        alloc_oh    = '0;
        alloc_oh[i] = 1'b1;
      end
    end
  end

  assign alloc_vec = alloc_oh & {DEPTH{do_alloc}};

  // Loads have no data operand, so rdy2 starts set
  always_comb begin
    new_ent         = '0;
    new_ent.is_st   = dc_is_st;
    new_ent.rob_idx = dc_rob_idx;
    new_ent.lsq_idx = dc_lsq_idx;
    new_ent.rs1_tag = dc_rs1_tag;
    new_ent.rs2_tag = dc_rs2_tag;
    new_ent.rdy1    = dc_rs1_rdy | tag_hit(dc_rs1_tag);
    new_ent.rdy2    = ~dc_is_st | dc_rs2_rdy | tag_hit(dc_rs2_tag);
    new_ent.imm     = dc_imm;
    new_ent.funct3  = dc_funct3;
  end

  always_comb begin
    req       = '0;
    flush_clr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      req[i]       = valid_q[i] & ent_q[i].rdy1 & ent_q[i].rdy2;
      flush_clr[i] = mispredict & valid_q[i] & flush_mask[ent_q[i].rob_idx];
    end
  end

  age_matrix_select #(.DEPTH(DEPTH)) u_age (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .alloc       (alloc_vec),
    .clear       (issue_clr | flush_clr),
    .grant       (grant),
    .grant_valid (is_valid)
  );

  assign issue_clr = grant & {DEPTH{is_valid & is_ready}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_vec[i]) begin
          valid_q[i] <= 1'b1;
          ent_q[i]   <= new_ent;
        end else begin
          if (issue_clr[i] || flush_clr[i]) valid_q[i] <= 1'b0;
          if (tag_hit(ent_q[i].rs1_tag)) ent_q[i].rdy1 <= 1'b1;
          if (tag_hit(ent_q[i].rs2_tag)) ent_q[i].rdy2 <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) sel = ent_q[i];
    end
  end

  assign is_st      = sel.is_st;
  assign is_rob_idx = sel.rob_idx;
  assign is_lsq_idx = sel.lsq_idx;
  assign is_rs1_tag = sel.rs1_tag;
  assign is_rs2_tag = sel.rs2_tag;
  assign is_imm     = sel.imm;
  assign is_funct3  = sel.funct3;

endmodule

// File: tb/tb_lsu_issue_queue.sv
// tb/tb_lsu_issue_queue.sv - directed scoreboard bench for lsu_issue_queue
module tb_lsu_issue_queue;
  import ooo_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        dc_valid, dc_is_st, dc_rs1_rdy, dc_rs2_rdy, dc_ready;
  logic [2:0]  dc_rob_idx, dc_funct3;
  logic [1:0]  dc_lsq_idx;
  logic [6:0]  dc_rs1_tag, dc_rs2_tag;
  logic [31:0] dc_imm;
  logic [1:0]  wb_valid;
  logic [13:0] wb_tag;
  logic        is_valid, is_ready, is_st;
  logic [2:0]  is_rob_idx, is_funct3;
  logic [1:0]  is_lsq_idx;
  logic [6:0]  is_rs1_tag, is_rs2_tag;
  logic [31:0] is_imm;
  logic        mispredict;
  logic [7:0]  flush_mask;

  typedef struct {
    logic        st;
    logic [2:0]  rob;
    logic [1:0]  lsq;
    logic [31:0] imm;
    logic [2:0]  f3;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  lsu_issue_queue dut (
    .clk(clk), .rst(rst),
    .dc_valid(dc_valid), .dc_is_st(dc_is_st), .dc_rob_idx(dc_rob_idx),
    .dc_lsq_idx(dc_lsq_idx), .dc_rs1_tag(dc_rs1_tag), .dc_rs2_tag(dc_rs2_tag),
    .dc_rs1_rdy(dc_rs1_rdy), .dc_rs2_rdy(dc_rs2_rdy), .dc_imm(dc_imm),
    .dc_funct3(dc_funct3), .dc_ready(dc_ready),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .is_valid(is_valid), .is_ready(is_ready), .is_st(is_st),
    .is_rob_idx(is_rob_idx), .is_lsq_idx(is_lsq_idx), .is_rs1_tag(is_rs1_tag),
    .is_rs2_tag(is_rs2_tag), .is_imm(is_imm), .is_funct3(is_funct3),
    .mispredict(mispredict), .flush_mask(flush_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    dc_valid   = 1'b0;
    wb_valid   = '0;
    mispredict = 1'b0;
    flush_mask = '0;
  endtask

  function automatic logic [31:0] imm_of(input logic [2:0] rob);
    return 32'hFFFF_FF00 | {29'd0, rob};
  endfunction

  task automatic drive_dc(input logic st, input logic [2:0] rob, input logic [1:0] lsq,
                          input logic [6:0] t1, input logic [6:0] t2,
                          input logic r1, input logic r2);
    dc_valid   = 1'b1;
    dc_is_st   = st;
    dc_rob_idx = rob;
    dc_lsq_idx = lsq;
    dc_rs1_tag = t1;
    dc_rs2_tag = t2;
    dc_rs1_rdy = r1;
    dc_rs2_rdy = r2;
    dc_imm     = imm_of(rob);
    dc_funct3  = st ? F3_SW : F3_LW;
  endtask

  task automatic dispatch(input logic st, input logic [2:0] rob, input logic [1:0] lsq,
                          input logic [6:0] t1, input logic [6:0] t2,
                          input logic r1, input logic r2);
    drive_dc(st, rob, lsq, t1, t2, r1, r2);
    cyc();
    dc_valid = 1'b0;
  endtask

  task automatic push(input logic st, input logic [2:0] rob, input logic [1:0] lsq);
    sb.push_back('{st, rob, lsq, imm_of(rob), st ? F3_SW : F3_LW});
  endtask

  task automatic exp_issue(input string tag);
    exp_t e;
    chk({tag, ".valid"}, is_valid, 1);
    chk({tag, ".sb_nonempty"}, sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".rob"}, is_rob_idx, e.rob);
      chk({tag, ".lsq"}, is_lsq_idx, e.lsq);
      chk({tag, ".st"}, is_st, e.st);
      chk({tag, ".imm"}, is_imm, e.imm);
      chk({tag, ".f3"}, is_funct3, e.f3);
    end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    is_ready = 1'b0;
    drive_dc(0, 0, 0, 0, 0, 0, 0);
    dc_valid = 1'b0;
    repeat (2) cyc();
    chk("rst.dc_ready", dc_ready, 1);
    chk("rst.is_valid", is_valid, 0);
    chk("rst.is_rob", is_rob_idx, 0);
    chk("rst.is_imm", is_imm, 0);
    rst = 1'b1;
    cyc();

    // single ready load issues one cycle after dispatch
    is_ready = 1'b1;
    push(0, 2, 1);
    dispatch(0, 3'd2, 2'd1, 7'd5, 7'd0, 1, 0);
    exp_issue("ld1");
    chk("ld1.rs1_tag", is_rs1_tag, 5);
    cyc();
    chk("ld1.freed", is_valid, 0);
    chk("ld1.dc_ready", dc_ready, 1);

    // fill with pending tag 9, wake together, drain in age order
    is_ready = 1'b0;
    for (int k = 0; k < 4; k++) dispatch(0, 3'(k), 2'(k), 7'd9, 7'd0, 0, 0);
    chk("full.dc_ready", dc_ready, 0);
    chk("full.is_valid", is_valid, 0);
    wb_valid = 2'b01;
    wb_tag   = {7'd0, 7'd9};
    for (int k = 0; k < 4; k++) push(0, 3'(k), 2'(k));
    cyc();
    idle();
    is_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_issue($sformatf("fill%0d", k));
      cyc();
    end
    chk("fill.empty", is_valid, 0);

    // store waits for data operand; unqualified tag match must not wake it
    dispatch(1, 3'd4, 2'd2, 7'd11, 7'd12, 1, 0);
    chk("st.wait0", is_valid, 0);
    wb_tag = {7'd12, 7'd12};
    cyc();
    chk("st.novalid_wb", is_valid, 0);
    wb_valid = 2'b10;
    chk("st.wb_cycle", is_valid, 0);
    push(1, 4, 2);
    cyc();
    idle();
    exp_issue("st");
    chk("st.rs2_tag", is_rs2_tag, 12);
    cyc();
    chk("st.freed", is_valid, 0);

    // younger op in a lower slot must still issue after older ones
    is_ready = 1'b0;
    dispatch(0, 3'd0, 2'd0, 7'd20, 7'd0, 1, 0);
    dispatch(0, 3'd1, 2'd1, 7'd20, 7'd0, 0, 0);
    dispatch(1, 3'd2, 2'd2, 7'd20, 7'd1, 0, 1);
    push(0, 0, 0);
    is_ready = 1'b1;
    exp_issue("age.a");
    cyc();
    is_ready = 1'b0;
    dispatch(0, 3'd3, 2'd3, 7'd20, 7'd0, 0, 0);
    chk("age.none", is_valid, 0);
    wb_valid = 2'b01;
    wb_tag   = {7'd0, 7'd20};
    push(0, 1, 1);
    push(1, 2, 2);
    push(0, 3, 3);
    cyc();
    idle();
    is_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_issue($sformatf("age%0d", k));
      cyc();
    end
    chk("age.empty", is_valid, 0);

    // flush rob 3 and 5, drop same-cycle dispatch
    is_ready = 1'b0;
    dispatch(0, 3'd1, 2'd0, 7'd30, 7'd0, 0, 0);
    dispatch(0, 3'd3, 2'd1, 7'd30, 7'd0, 0, 0);
    dispatch(0, 3'd5, 2'd2, 7'd30, 7'd0, 0, 0);
    drive_dc(0, 3'd6, 2'd3, 7'd0, 7'd0, 1, 0);
    mispredict = 1'b1;
    flush_mask = 8'b0010_1000;
    cyc();
    idle();
    chk("flush.drop6", is_valid, 0);
    wb_valid = 2'b01;
    wb_tag   = {7'd0, 7'd30};
    push(0, 1, 0);
    cyc();
    idle();
    is_ready = 1'b1;
    exp_issue("flush.keep1");
    cyc();
    chk("flush.empty", is_valid, 0);

    // wake at dispatch, then issue and flush of the same entry together
    drive_dc(0, 3'd7, 2'd0, 7'd40, 7'd0, 0, 0);
    wb_valid = 2'b01;
    wb_tag   = {7'd0, 7'd40};
    push(0, 7, 0);
    cyc();
    idle();
    exp_issue("wdisp");
    mispredict = 1'b1;
    flush_mask = 8'h80;
    cyc();
    idle();
    chk("isfl.gone", is_valid, 0);
    chk("isfl.dc_ready", dc_ready, 1);

    // held offer while is_ready is low
    is_ready = 1'b0;
    push(0, 4, 2);
    dispatch(0, 3'd4, 2'd2, 7'd3, 7'd0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d.valid", k), is_valid, 1);
      chk($sformatf("hold%0d.rob", k), is_rob_idx, 4);
      cyc();
    end
    is_ready = 1'b1;
    exp_issue("hold");
    cyc();
    chk("hold.once", is_valid, 0);

    // asynchronous reset with three valid ready entries
    is_ready = 1'b0;
    for (int k = 0; k < 3; k++) dispatch(0, 3'(k), 2'(k), 7'd2, 7'd0, 1, 0);
    chk("mrst.pre_valid", is_valid, 1);
    chk("mrst.pre_dc_ready", dc_ready, 1);
    rst = 1'b0;
    #1;
    chk("mrst.is_valid", is_valid, 0);
    chk("mrst.dc_ready", dc_ready, 1);
    chk("mrst.is_st", is_st, 0);
    chk("mrst.is_lsq", is_lsq_idx, 0);
    chk("mrst.is_imm", is_imm, 0);
    chk("mrst.is_f3", is_funct3, 0);
    chk("mrst.is_rs1", is_rs1_tag, 0);
    cyc();
    rst = 1'b1;
    cyc();
    chk("mrst.post_valid", is_valid, 0);
    chk("sb.drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
